// File: rtl/dmem_port_if.sv
// Word-addressed SRAM-style request/acknowledge bus between dmem_port and data memory.
// master = dmem_port side, slave = memory side.
interface dmem_port_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dmem_port.sv
// Core load/store responder: validates, lane-aligns and issues one bus access per request,
// then extends load data. Optional macro DMEM_SPLIT_EN splits word-crossing accesses in two.
module dmem_port #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  dmem_port_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

`ifdef DMEM_SPLIT_EN
  typedef enum logic [1:0] {StIdle, StAccess, StDone, StAccess2} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
`endif

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              load_q, load_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
`ifdef DMEM_SPLIT_EN
  logic              split_q, split_d;
  logic [3:0]        be2_q, be2_d;
  logic [31:0]       wdata2_q, wdata2_d;
  logic [31:0]       buf_q, buf_d;
  logic              crossing;
`endif

  logic        req, is_store, illegal, misal, bad, in_access;
  logic [1:0]  size, off;
  logic [3:0]  mask;
  logic [31:0] data_repl, data_lane, ld_word;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic uns);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {{24{d[7] & ~uns}}, d[7:0]};
      2'b01:   r = {{16{d[15] & ~uns}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request decode and validation, all in the request cycle.
  always_comb begin
    req      = dmem_read | dmem_write;
    is_store = dmem_write;
    size     = funct3[1:0];
    off      = addr[1:0];
    illegal  = (size == 2'b11) | (is_store & funct3[2]);
    misal    = ((size == 2'b01) & off[0]) | ((size == 2'b10) & (off != 2'b00));
    case (size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    case (size)
      2'b00:   data_repl = {4{wdata[7:0]}};
      2'b01:   data_repl = {2{wdata[15:0]}};
      default: data_repl = wdata;
    endcase
`ifdef DMEM_SPLIT_EN
    crossing  = ((size == 2'b01) & (off == 2'b11)) | ((size == 2'b10) & (off != 2'b00));
    bad       = illegal;
    data_lane = misal ? (wdata << {off, 3'b000}) : data_repl;
`else
    bad       = illegal | misal;
    data_lane = data_repl;
`endif
  end

  always_comb begin
    in_access = (state_q == StAccess);
`ifdef DMEM_SPLIT_EN
    in_access = in_access | (state_q == StAccess2);
`endif
    busy = ~rst & (((state_q == StIdle) & req) | in_access);
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_d      = load_q;
    uns_d       = uns_q;
    size_d      = size_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    fault_d     = 1'b0;
`ifdef DMEM_SPLIT_EN
    split_d     = split_q;
    be2_d       = be2_q;
    wdata2_d    = wdata2_q;
    buf_d       = buf_q;
    ld_word     = split_q ? 32'({bus.mem_rdata, buf_q} >> {off_q, 3'b000})
                          : (bus.mem_rdata >> {off_q, 3'b000});
`else
    ld_word     = bus.mem_rdata >> {off_q, 3'b000};
`endif

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (bad) begin
            fault_d = 1'b1;
          end else begin
            state_d     = StAccess;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = addr[ADDR_W+1:2];
            mem_be_d    = mask << off;
            mem_wdata_d = data_lane;
            load_d      = ~is_store;
            uns_d       = funct3[2];
            size_d      = size;
            off_d       = off;
            cnt_d       = '0;
`ifdef DMEM_SPLIT_EN
            split_d     = crossing;
            be2_d       = mask >> (3'd4 - {1'b0, off});
            wdata2_d    = wdata >> (6'd32 - {1'b0, off, 3'b000});
`endif
          end
        end
      end
      StAccess: begin
        if (bus.mem_ack) begin
`ifdef DMEM_SPLIT_EN
          if (split_q) begin
            // First half done: keep mem_req high and move to the following word.
            state_d     = StAccess2;
            buf_d       = bus.mem_rdata;
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            mem_be_d    = be2_q;
            mem_wdata_d = wdata2_q;
            cnt_d       = '0;
          end else begin
            state_d   = StDone;
            mem_req_d = 1'b0;
            if (load_q) rdata_d = extend(ld_word, size_q, uns_q);
          end
`else
          state_d   = StDone;
          mem_req_d = 1'b0;
          if (load_q) rdata_d = extend(ld_word, size_q, uns_q);
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(TIMEOUT)) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
            fault_d   = 1'b1;
          end
        end
      end
`ifdef DMEM_SPLIT_EN
      StAccess2: begin
        if (bus.mem_ack) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          if (load_q) rdata_d = extend(ld_word, size_q, uns_q);
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(TIMEOUT)) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
            fault_d   = 1'b1;
          end
        end
      end
`endif
      StDone: begin
        // Requests seen here are dropped; the core re-presents them once the stall is released.
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      load_q      <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
`ifdef DMEM_SPLIT_EN
      split_q     <= 1'b0;
      be2_q       <= '0;
      wdata2_q    <= '0;
      buf_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_q      <= load_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
`ifdef DMEM_SPLIT_EN
      split_q     <= split_d;
      be2_q       <= be2_d;
      wdata2_q    <= wdata2_d;
      buf_q       <= buf_d;
`endif
    end
  end

  assign rdata         = rdata_q;
  assign rdata_valid   = (state_q == StDone) & load_q;
  assign fault         = fault_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port (default build): inputs change 1 ns after posedge,
// outputs are sampled on negedge and compared with hand-computed values.
module tb_dmem_port;

  logic        clk;
  logic        rst;
  logic        dmem_read;
  logic        dmem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;

  int n_checks;
  int n_errors;

  dmem_port_if #(.ADDR_W(16)) mem_bus ();

  dmem_port #(
    .ADDR_W (16),
    .TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .fault      (fault),
    .bus        (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    dmem_read  = rd;
    dmem_write = wr;
    funct3     = f3;
    addr       = a;
    wdata      = wd;
  endtask

  task automatic clr_req();
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
  endtask

  // Single load with ack after `lat` cycles in ACCESS; checks rdata one cycle after ack.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] mrd, input int lat, input logic [31:0] exp);
    set_req(1'b1, 1'b0, f3, a, 32'h0);
    sample();
    check_eq({tag, "_busy0"}, 32'(busy), 32'd1);
    next_cycle();
    clr_req();
    for (int i = 0; i < lat; i++) begin
      sample();
      check_eq({tag, "_req_wait"}, 32'(mem_bus.mem_req), 32'd1);
      next_cycle();
    end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = mrd;
    sample();
    check_eq({tag, "_rv_ack"}, 32'(rdata_valid), 32'd0);
    next_cycle();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'hDEAD_BEEF;
    sample();
    check_eq({tag, "_rv"}, 32'(rdata_valid), 32'd1);
    check_eq({tag, "_rdata"}, rdata, exp);
    check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    next_cycle();
    sample();
    check_eq({tag, "_rv_off"}, 32'(rdata_valid), 32'd0);
    check_eq({tag, "_rdata_hold"}, rdata, exp);
    next_cycle();
  endtask

  // Request that must be rejected: fault pulse next cycle, no bus request.
  task automatic do_bad(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a);
    set_req(rd, wr, f3, a, 32'h1234_5678);
    sample();
    check_eq({tag, "_busy0"}, 32'(busy), 32'd1);
    next_cycle();
    clr_req();
    sample();
    check_eq({tag, "_fault"}, 32'(fault), 32'd1);
    check_eq({tag, "_noreq"}, 32'(mem_bus.mem_req), 32'd0);
    check_eq({tag, "_busy1"}, 32'(busy), 32'd0);
    next_cycle();
    sample();
    check_eq({tag, "_fault_off"}, 32'(fault), 32'd0);
    check_eq({tag, "_noreq2"}, 32'(mem_bus.mem_req), 32'd0);
    next_cycle();
  endtask

  initial begin
    int req_cycles;
    int faults;
    int valids;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;

    // Reset state
    next_cycle();
    next_cycle();
    sample();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_rv", 32'(rdata_valid), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_bus.mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    check_eq("rst_be", 32'(mem_bus.mem_be), 32'd0);
    check_eq("rst_wdata", mem_bus.mem_wdata, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // sb 0x13, ack in the first ACCESS cycle
    set_req(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_00AB);
    sample();
    check_eq("sb_busy0", 32'(busy), 32'd1);
    check_eq("sb_req0", 32'(mem_bus.mem_req), 32'd0);
    next_cycle();
    clr_req();
    mem_bus.mem_ack = 1'b1;
    sample();
    check_eq("sb_busy1", 32'(busy), 32'd1);
    check_eq("sb_req1", 32'(mem_bus.mem_req), 32'd1);
    check_eq("sb_we", 32'(mem_bus.mem_we), 32'd1);
    check_eq("sb_addr", 32'(mem_bus.mem_addr), 32'd4);
    check_eq("sb_be", 32'(mem_bus.mem_be), 32'b1000);
    check_eq("sb_wdata", mem_bus.mem_wdata, 32'hABAB_ABAB);
    next_cycle();
    mem_bus.mem_ack = 1'b0;
    sample();
    check_eq("sb_busy2", 32'(busy), 32'd0);
    check_eq("sb_req2", 32'(mem_bus.mem_req), 32'd0);
    check_eq("sb_rv2", 32'(rdata_valid), 32'd0);
    next_cycle();

    // sh 0x6: upper half-word lanes
    set_req(1'b0, 1'b1, 3'b001, 32'h6, 32'h1234_BEEF);
    next_cycle();
    clr_req();
    sample();
    check_eq("sh_addr", 32'(mem_bus.mem_addr), 32'd1);
    check_eq("sh_be", 32'(mem_bus.mem_be), 32'b1100);
    check_eq("sh_wdata", mem_bus.mem_wdata, 32'hBEEF_BEEF);
    mem_bus.mem_ack = 1'b1;
    next_cycle();
    mem_bus.mem_ack = 1'b0;
    next_cycle();

    // Loads
    do_load("lb", 3'b000, 32'h13, 32'h8012_3456, 0, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h13, 32'h8012_3456, 0, 32'h0000_0080);
    do_load("lhu", 3'b101, 32'h2, 32'h8001_5555, 1, 32'h0000_8001);
    do_load("lw", 3'b010, 32'h4, 32'hCAFE_1234, 0, 32'hCAFE_1234);

    // lh 0x2 with ack delayed three cycles: bus held stable
    set_req(1'b1, 1'b0, 3'b001, 32'h2, 32'h0);
    next_cycle();
    clr_req();
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("lh_req_hold", 32'(mem_bus.mem_req), 32'd1);
      check_eq("lh_addr_hold", 32'(mem_bus.mem_addr), 32'd0);
      check_eq("lh_be_hold", 32'(mem_bus.mem_be), 32'b1100);
      check_eq("lh_we_hold", 32'(mem_bus.mem_we), 32'd0);
      check_eq("lh_busy_hold", 32'(busy), 32'd1);
      next_cycle();
    end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h8001_5555;
    next_cycle();
    mem_bus.mem_ack = 1'b0;
    sample();
    check_eq("lh_rv", 32'(rdata_valid), 32'd1);
    check_eq("lh_rdata", rdata, 32'hFFFF_8001);
    next_cycle();

    // lw 0x8 never acked: timeout after 15 request cycles
    set_req(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    next_cycle();
    clr_req();
    req_cycles = 0;
    faults     = 0;
    valids     = 0;
    for (int i = 1; i <= 20; i++) begin
      sample();
      if (mem_bus.mem_req) req_cycles++;
      if (fault) faults++;
      if (rdata_valid) valids++;
      if (i == 16) begin
        check_eq("to_fault16", 32'(fault), 32'd1);
        check_eq("to_req16", 32'(mem_bus.mem_req), 32'd0);
        check_eq("to_busy16", 32'(busy), 32'd0);
      end
      next_cycle();
    end
    check_eq("to_req_cycles", 32'(req_cycles), 32'd15);
    check_eq("to_fault_count", 32'(faults), 32'd1);
    check_eq("to_rv_count", 32'(valids), 32'd0);
    check_eq("to_rdata_kept", rdata, 32'hFFFF_8001);

    // Rejected requests
    do_bad("lw_mis", 1'b1, 1'b0, 3'b010, 32'h5);
    do_bad("lh_mis", 1'b1, 1'b0, 3'b001, 32'h1);
    do_bad("sz11", 1'b1, 1'b0, 3'b011, 32'h0);
    do_bad("sh_uns", 1'b0, 1'b1, 3'b101, 32'h0);
    do_bad("sw_mis", 1'b0, 1'b1, 3'b010, 32'h2);

    // Both read and write: treated as a store
    set_req(1'b1, 1'b1, 3'b010, 32'hC, 32'h5A5A_0F0F);
    next_cycle();
    clr_req();
    sample();
    check_eq("rw_we", 32'(mem_bus.mem_we), 32'd1);
    check_eq("rw_addr", 32'(mem_bus.mem_addr), 32'd3);
    check_eq("rw_be", 32'(mem_bus.mem_be), 32'b1111);
    check_eq("rw_wdata", mem_bus.mem_wdata, 32'h5A5A_0F0F);
    mem_bus.mem_ack = 1'b1;
    next_cycle();
    mem_bus.mem_ack = 1'b0;
    sample();
    check_eq("rw_rv", 32'(rdata_valid), 32'd0);

    // Request presented in DONE is ignored
    set_req(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
    #1;
    check_eq("done_busy", 32'(busy), 32'd0);
    next_cycle();
    clr_req();
    sample();
    check_eq("done_noreq", 32'(mem_bus.mem_req), 32'd0);
    next_cycle();

    // mem_ack while idle is ignored
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h1111_1111;
    sample();
    check_eq("idle_ack_busy", 32'(busy), 32'd0);
    next_cycle();
    mem_bus.mem_ack = 1'b0;
    sample();
    check_eq("idle_ack_rv", 32'(rdata_valid), 32'd0);
    check_eq("idle_ack_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("idle_ack_rdata", rdata, 32'hFFFF_8001);
    next_cycle();

    // Reset in the middle of an access
    set_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    next_cycle();
    clr_req();
    rst = 1'b1;
    sample();
    check_eq("mid_req_before", 32'(mem_bus.mem_req), 32'd1);
    next_cycle();
    rst = 1'b0;
    sample();
    check_eq("mid_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_fault", 32'(fault), 32'd0);
    check_eq("mid_rv", 32'(rdata_valid), 32'd0);
    check_eq("mid_rdata", rdata, 32'd0);
    check_eq("mid_addr", 32'(mem_bus.mem_addr), 32'd0);
    next_cycle();
    sample();
    check_eq("mid_fault2", 32'(fault), 32'd0);
    check_eq("mid_rv2", 32'(rdata_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Data-memory responder for the core's load/store control signals (dmem_read, dmem_write, funct3).
- Accepts one access per request and drives a word-addressed SRAM-style bus with req/ack handshake.
- Handles byte-lane alignment of stores, and sign/zero extension of loads.
- Stalls the core via busy until the access completes, faults or times out.

Parameters:
ADDR_W, 16, word-address width on the memory side (byte address bits [ADDR_W+1:2] used).
TIMEOUT, 15, max cycles mem_req is held without mem_ack before fault; counter width $clog2(TIMEOUT+1).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
dmem_read  input  1  load request from control
dmem_write  input  1  store request from control
funct3  input  3  size[1:0] (00 B, 01 H, 10 W); bit2 = unsigned load
addr  input  32  byte address (ALU result)
wdata  input  32  store data (rs2)
busy  output  1  stall core
rdata  output  32  extended load data
rdata_valid  output  1  one-cycle pulse, rdata valid
fault  output  1  one-cycle pulse: illegal size, misalignment or timeout
mem_req  output  1  bus request
mem_we  output  1  bus write enable
mem_addr  output  ADDR_W  word address
mem_be  output  4  byte enables
mem_wdata  output  32  lane-aligned write data
mem_rdata  input  32  read data, valid in mem_ack cycle
mem_ack  input  1  access complete

Behaviour:
- States: IDLE, ACCESS, DONE (+ ACCESS2 with DMEM_SPLIT_EN). Reset: state IDLE; all outputs 0, including rdata.
- IDLE: request = dmem_read | dmem_write; both high is treated as a store.
- Validation occurs in the request cycle:
  - size 11 is illegal.
  - store with funct3[2]=1 is illegal.
  - Misaligned = H with addr[0]=1, or W with addr[1:0]!=0.
- Illegal or misaligned request: fault pulses the next cycle; state stays IDLE; no bus activity.
- Valid request: register mem_addr/mem_we/mem_be/mem_wdata and the load-extension controls; enter ACCESS with mem_req=1.
- busy = request_in_IDLE | (state==ACCESS) | (state==ACCESS2). busy is combinational, so the core stalls in the request cycle.
- Store lanes: B: be=1<<addr[1:0], wdata[7:0] replicated to all lanes; H: be=0011<<addr[1:0], wdata[15:0] replicated; W: be=1111.
- ACCESS: hold all mem_* stable until mem_ack.
- On mem_ack: capture mem_rdata, shifted right by 8*addr[1:0], then sign-/zero-extend per funct3 into rdata. Drop mem_req; go to DONE.
- mem_ack seen in the same cycle mem_req first rises is legal: latency is request cycle 0, ack cycle 1 earliest, rdata_valid cycle 2.
- DONE: rdata_valid=1 for loads only (stores: no pulse); busy=0; return to IDLE.
  - A new request in DONE is ignored. The core must re-present it; it does so naturally because the stall released.
- rdata holds its value until the next load completes.
- Timeout: counter clears on entering ACCESS and increments each non-ack cycle. When it reaches TIMEOUT: drop mem_req, pulse fault, go to IDLE, no rdata_valid.
- mem_ack while in IDLE/DONE is ignored.
- Reset mid-access: mem_req drops at that edge; the access is abandoned with no fault or rdata_valid pulse.

Optional Feature:
- Macro DMEM_SPLIT_EN.
- Defined:
  - Misaligned accesses within one word (H at offset 1) complete in one access.
  - Crossing accesses (H at offset 3, W at offsets 1-3) split into two: ACCESS at word addr>>2 with upper lanes, then ACCESS2 at word+1 with lower lanes.
  - Load data is merged from both acks before extension.
  - Timeout applies per phase.
  - Split word address wraps modulo 2^ADDR_W.
- Undefined: any misalignment faults as described; ACCESS2 is not built.

Test Plan:
- sb addr=0x13 wdata=0x000000AB, ack cycle 1 -> mem_addr=4, mem_be=1000, mem_wdata[31:24]=0xAB, mem_we=1, busy high cycles 0-1, no rdata_valid.
- lb addr=0x13, mem_rdata=0x80123456 -> rdata=0xFFFFFF80 with rdata_valid at cycle 2; lbu same -> 0x00000080.
- lh addr=0x2, mem_rdata=0x8001_5555, ack delayed 3 cycles -> mem_* stable throughout; rdata=0xFFFF8001 one cycle after ack.
- lw addr=0x8, ack never, TIMEOUT=15 -> mem_req drops after 15 cycles, single fault pulse, busy low, no rdata_valid.
- lw addr=0x5 -> fault pulse, no mem_req. With DMEM_SPLIT_EN: mem_addr=1 be=1110, then mem_addr=2 be=0001; rdata = {w2[7:0], w1[31:8]}.
- funct3=011 load; sh with funct3[2]=1; rst asserted during ACCESS -> fault for the illegal cases; on rst, mem_req=0 next edge, state IDLE, all outputs 0.
